// File: rtl/x_stream_pkg.sv
// Shared defaults and state encoding for the x-stream frame transmitter.
package x_stream_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_LENX  = 64;
    localparam int DEF_ADDRX = $clog2(DEF_LENX);

    typedef enum logic {
        TX_IDLE,
        TX_RUN
    } tx_state_t;

endpackage

// File: rtl/memory.sv
// Single-port frame bank: synchronous write, one-cycle registered read.
module memory #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    parameter int ADDRW = 6
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDRW-1:0]        addr,
    input  logic signed [WIDTH-1:0] wdata,
    output logic signed [WIDTH-1:0] rdata
);

    logic signed [WIDTH-1:0] mem [DEPTH];

    // Write when enabled; the addressed word is always read back one cycle later.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/stream_skid.sv
// Two-entry valid/ready buffer. The producer only pushes when it has
// reserved space using count, so there is no input-side ready.
module stream_skid #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_data,
    output logic [1:0]              count
);

    logic                    v0_p0, v1_p0;
    logic signed [WIDTH-1:0] d0_p0, d1_p0;
    logic                    pop;

    assign pop       = v0_p0 && out_ready;
    assign out_valid = v0_p0;
    assign out_data  = d0_p0;
    assign count     = {v1_p0, v0_p0 & ~v1_p0};

    // Occupancy flags: entry 0 is the head, entry 1 only valid behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            v0_p0 <= 1'b0;
            v1_p0 <= 1'b0;
        end else if (pop) begin
            if (v1_p0) begin
                v0_p0 <= 1'b1;
                v1_p0 <= in_valid;
            end else begin
                v0_p0 <= in_valid;
                v1_p0 <= 1'b0;
            end
        end else if (in_valid) begin
            if (v0_p0) begin
                v1_p0 <= 1'b1;
            end else begin
                v0_p0 <= 1'b1;
            end
        end
    end

    // Data slots follow the same shift/fill pattern as the flags, without reset.
    always_ff @(posedge clk) begin
        if (pop) begin
            if (v1_p0) begin
                d0_p0 <= d1_p0;
                if (in_valid) begin
                    d1_p0 <= in_data;
                end
            end else if (in_valid) begin
                d0_p0 <= in_data;
            end
        end else if (in_valid) begin
            if (v0_p0) begin
                d1_p0 <= in_data;
            end else begin
                d0_p0 <= in_data;
            end
        end
    end

endmodule

// File: rtl/x_stream_tx.sv
// Double-buffered frame transmitter: load a bank by address, commit it,
// and the committed frames are streamed out word 0 first.
module x_stream_tx
    import x_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LENX  = DEF_LENX,
    parameter int ADDRX = DEF_ADDRX
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDRX-1:0]        wr_addr,
    input  logic signed [WIDTH-1:0] wr_data,
    input  logic                    commit,
    output logic                    commit_ready,
    output logic signed [WIDTH-1:0] m_data_out_x,
    output logic                    m_valid_x,
    input  logic                    m_ready_x,
    output logic                    frame_done
);

    localparam logic [ADDRX-1:0] LAST    = ADDRX'(LENX - 1);
    localparam logic [ADDRX:0]   LEN_EXT = (ADDRX + 1)'(LENX);

    tx_state_t               state, state_nxt;
    logic [1:0]              full;
    logic                    wb, rb;
    logic [ADDRX-1:0]        rd_addr, rd_addr_cur, tx_cnt;
    logic                    rd_done, rd_issue, rd_bank_cur, restart;
    logic                    rd_vld_p1, rd_bank_p1;
    logic signed [WIDTH-1:0] rdata0, rdata1, skid_in;
    logic [1:0]              skid_cnt;
    logic [2:0]              occ_nxt;
    logic                    hs, last_hs, issue_ok, commit_ok, wr_ok;
    logic                    we0, we1;
    logic [ADDRX-1:0]        addr0, addr1;

    assign commit_ready = !full[wb];
    assign commit_ok    = commit && commit_ready;
    assign wr_ok        = wr_en && commit_ready && ({1'b0, wr_addr} < LEN_EXT);
    assign hs           = m_valid_x && m_ready_x;
    assign last_hs      = hs && (tx_cnt == LAST);

    // Words held after this edge plus the read launched now must fit in the skid.
    assign occ_nxt  = {1'b0, skid_cnt} + {2'b00, rd_vld_p1} - {2'b00, hs};
    assign issue_ok = occ_nxt < 3'd2;

    // A bank is written only while not full and read only while full, so one port suffices.
    assign we0   = wr_ok && !wb;
    assign we1   = wr_ok &&  wb;
    assign addr0 = we0 ? wr_addr : rd_addr_cur;
    assign addr1 = we1 ? wr_addr : rd_addr_cur;

    memory #(.WIDTH(WIDTH), .DEPTH(LENX), .ADDRW(ADDRX)) u_bank0 (
        .clk   (clk),
        .we    (we0),
        .addr  (addr0),
        .wdata (wr_data),
        .rdata (rdata0)
    );

    memory #(.WIDTH(WIDTH), .DEPTH(LENX), .ADDRW(ADDRX)) u_bank1 (
        .clk   (clk),
        .we    (we1),
        .addr  (addr1),
        .wdata (wr_data),
        .rdata (rdata1)
    );

    assign skid_in = rd_bank_p1 ? rdata1 : rdata0;

    stream_skid #(.WIDTH(WIDTH)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_vld_p1),
        .in_data   (skid_in),
        .out_ready (m_ready_x),
        .out_valid (m_valid_x),
        .out_data  (m_data_out_x),
        .count     (skid_cnt)
    );

    // Next state and read launch; on the last handshake a full other bank starts immediately.
    always_comb begin
        state_nxt   = state;
        rd_issue    = 1'b0;
        rd_addr_cur = rd_addr;
        rd_bank_cur = rb;
        restart     = 1'b0;
        case (state)
            TX_IDLE: begin
                if (full[rb]) begin
                    state_nxt   = TX_RUN;
                    rd_issue    = 1'b1;
                    rd_addr_cur = '0;
                    restart     = 1'b1;
                end
            end
            TX_RUN: begin
                if (last_hs) begin
                    if (full[!rb]) begin
                        rd_issue    = 1'b1;
                        rd_addr_cur = '0;
                        rd_bank_cur = !rb;
                        restart     = 1'b1;
                    end else begin
                        state_nxt = TX_IDLE;
                    end
                end else if (!rd_done && issue_ok) begin
                    rd_issue = 1'b1;
                end
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= TX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bank ownership: commit fills the write bank, the final handshake frees the read bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 2'b00;
            wb   <= 1'b0;
            rb   <= 1'b0;
        end else begin
            if (commit_ok) begin
                full[wb] <= 1'b1;
                wb       <= !wb;
            end
            if (last_hs) begin
                full[rb] <= 1'b0;
                rb       <= !rb;
            end
        end
    end

    // Read address sequencing within a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr <= '0;
            rd_done <= 1'b1;
        end else if (restart) begin
            rd_addr <= ADDRX'(1);
            rd_done <= (LENX == 1);
        end else if (rd_issue) begin
            rd_addr <= rd_addr + 1'b1;
            if (rd_addr == LAST) begin
                rd_done <= 1'b1;
            end
        end
    end

    // Output-side word count and end-of-frame pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_cnt     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_hs;
            if (last_hs) begin
                tx_cnt <= '0;
            end else if (hs) begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    // Stage p1: read valid alongside the RAM's registered output.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_p1 <= 1'b0;
        end else begin
            rd_vld_p1 <= rd_issue;
        end
    end

    // Stage p1: which bank the returning word comes from.
    always_ff @(posedge clk) begin
        rd_bank_p1 <= rd_bank_cur;
    end

endmodule
